// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU type definitions
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - saturating performance counter with increment and clear
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - pipeline stall/flush sequencer with performance counters
module hazard_sequencer
  import cpu_types_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic [REG_W-1:0] id_rsel1,
  input  logic [REG_W-1:0] id_rsel2,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic             ex_pcsrc,
  input  logic             wb_halt,
  input  logic             wb_valid,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  hazard_state_t state, state_n;
  logic mem_req, mem_ok, advance, lu, active;
  logic stall_inc, flush_inc, inst_inc;

  assign mem_req = mem_dREN | mem_dWEN;
  assign mem_ok  = !mem_req | dhit;
  assign advance = ihit & mem_ok;
  assign lu      = ex_dREN && (ex_wsel != '0) &&
                   ((ex_wsel == id_rsel1) || (ex_wsel == id_rsel2));
  // Latch controls stay low while reset is held, not just after the edge
  assign active  = nRST && (state != HALTED);
  assign halt    = (state == HALTED);

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;
    if (active) begin
      if (!advance) begin
        // A pending data access must not let the MEM/WB entry write back twice
        memwb_en    = !mem_ok;
        memwb_flush = !mem_ok;
      end else if (ex_pcsrc) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu) begin
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end

      if (wb_halt)                                  state_n = HALTED;
      else if ((state == RUN) && mem_req && !dhit)  state_n = MEMWAIT;
      else if ((state == MEMWAIT) && dhit)          state_n = RUN;
    end
  end

  assign stall_inc = active && !pc_en;
  assign flush_inc = active && advance && ex_pcsrc;
  assign inst_inc  = active && ((memwb_en && wb_valid && !memwb_flush) || wb_halt);

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK(CLK), .nRST(nRST), .inc(stall_inc), .clear(1'b0), .count(stall_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK(CLK), .nRST(nRST), .inc(flush_inc), .clear(1'b0), .count(flush_cnt)
  );

  perf_counter #(.CNT_W(CNT_W)) u_inst_cnt (
    .CLK(CLK), .nRST(nRST), .inc(inst_inc), .clear(1'b0), .count(inst_cnt)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - directed self-checking bench for hazard_sequencer
module tb_hazard_sequencer;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush}
  localparam logic [8:0] C_ALL  = 9'b110101010;
  localparam logic [8:0] C_BR   = 9'b111111010;
  localparam logic [8:0] C_LU   = 9'b000111010;
  localparam logic [8:0] C_MD   = 9'b000000011;
  localparam logic [8:0] C_NONE = 9'b000000000;

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_pcsrc, wb_halt, wb_valid;
  logic [REG_W-1:0] id_rsel1, id_rsel2, ex_wsel;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic             exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, inst_cnt;
  logic [8:0]       obs_ctrl;

  typedef struct packed {
    logic [8:0]       ctrl;
    logic             halt;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    logic [CNT_W-1:0] inst;
  } exp_t;

  exp_t             sb[$];
  int               compared = 0;
  int               failed   = 0;
  logic [CNT_W-1:0] m_stall, m_flush, m_inst;
  logic             m_halted;

  always #5 CLK = ~CLK;

  hazard_sequencer #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
    .id_rsel1(id_rsel1), .id_rsel2(id_rsel2),
    .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .ex_pcsrc(ex_pcsrc),
    .wb_halt(wb_halt), .wb_valid(wb_valid),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .memwb_flush(memwb_flush),
    .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .inst_cnt(inst_cnt)
  );

  assign obs_ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                     exmem_en, exmem_flush, memwb_en, memwb_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic i_ihit, input logic i_dhit, input logic i_dren,
                       input logic i_dwen, input logic [REG_W-1:0] rs,
                       input logic [REG_W-1:0] rt, input logic i_exdren,
                       input logic [REG_W-1:0] wsel, input logic pcsrc,
                       input logic whalt, input logic wvalid);
    ihit = i_ihit; dhit = i_dhit; mem_dREN = i_dren; mem_dWEN = i_dwen;
    id_rsel1 = rs; id_rsel2 = rt; ex_dREN = i_exdren; ex_wsel = wsel;
    ex_pcsrc = pcsrc; wb_halt = whalt; wb_valid = wvalid;
  endtask

  // Called at a falling edge with inputs already driven; predicts the cycle and checks it
  task automatic step(input string tag, input logic [8:0] ctrl);
    exp_t e;
    if (!m_halted) begin
      if (!ctrl[8])            m_stall++;
      if (ctrl[8] && ctrl[6])  m_flush++;
      if ((ctrl[1] && wb_valid && !ctrl[0]) || wb_halt) m_inst++;
      if (wb_halt)             m_halted = 1'b1;
    end
    e.ctrl = ctrl; e.halt = m_halted;
    e.stall = m_stall; e.flush = m_flush; e.inst = m_inst;
    sb.push_back(e);
    #2;
    chk({tag, ".ctrl"}, 32'(obs_ctrl), 32'(sb[0].ctrl));
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk({tag, ".halt"},  32'(halt), 32'(e.halt));
    chk({tag, ".stall"}, stall_cnt, e.stall);
    chk({tag, ".flush"}, flush_cnt, e.flush);
    chk({tag, ".inst"},  inst_cnt,  e.inst);
    @(negedge CLK);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ctrl"},  32'(obs_ctrl), 32'(C_NONE));
    chk({tag, ".halt"},  32'(halt), 32'd0);
    chk({tag, ".stall"}, stall_cnt, 32'd0);
    chk({tag, ".flush"}, flush_cnt, 32'd0);
    chk({tag, ".inst"},  inst_cnt,  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    m_stall = '0; m_flush = '0; m_inst = '0; m_halted = 1'b0;
    nRST = 1'b0;
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk_reset("reset_init");
    @(negedge CLK);
    nRST = 1'b1;

    drive(1, 0, 0, 0, 1, 2, 0, 3, 0, 0, 1);  step("advance", C_ALL);
    drive(1, 0, 0, 0, 3, 8, 1, 8, 0, 0, 1);  step("lu_rt", C_LU);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);  step("lu_r0", C_ALL);
    drive(1, 0, 0, 0, 9, 4, 1, 9, 0, 0, 0);  step("lu_rs", C_LU);
    drive(1, 0, 0, 0, 9, 4, 1, 9, 1, 0, 1);  step("br_lu", C_BR);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  step("imiss1", C_NONE);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);  step("imiss_br", C_NONE);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);  step("br_after_imiss", C_BR);

    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);  step($sformatf("dmiss%0d", i), C_MD);
    end
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);  step("dmiss_exit", C_ALL);

    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);  step("smiss", C_MD);
    drive(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1);  step("smiss_exit_imiss", C_NONE);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  step("resume", C_ALL);

    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);  step("pre_reset_miss", C_MD);
    nRST = 1'b0;
    #1;
    chk_reset("reset_memwait");
    m_stall = '0; m_flush = '0; m_inst = '0; m_halted = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  step("post_reset", C_ALL);
    drive(1, 0, 0, 0, 5, 6, 1, 6, 0, 0, 1);  step("post_reset_lu", C_LU);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);  step("halt_entry", C_ALL);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 0, 0, 0, 0, i[0], 0, 1);  step($sformatf("halted%0d", i), C_NONE);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. Drives the en/flush pair of every pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. Handles load-use hazards, cache-miss freezes, taken branch/jump squashes and halt drain. Keeps saturating performance counters.

Parameters:
REG_W, 5, register-select width.
CNT_W, 32, width of each performance counter.

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
ihit  in  1  icache returned the instruction this cycle
dhit  in  1  dcache completed the MEM-stage access this cycle
mem_dREN  in  1  MEM-stage load
mem_dWEN  in  1  MEM-stage store
id_rsel1  in  REG_W  ID-stage source reg rs
id_rsel2  in  REG_W  ID-stage source reg rt
ex_dREN  in  1  EX-stage instruction is a load
ex_wsel  in  REG_W  EX-stage destination reg
ex_pcsrc  in  1  EX-stage branch taken or jump/JAL/JR redirect
wb_halt  in  1  halt at MEM/WB output
wb_valid  in  1  MEM/WB holds a non-bubble instruction
pc_en  out  1  PC update enable
ifid_en, ifid_flush  out  1 each  IF/ID latch control
idex_en, idex_flush  out  1 each  ID/EX latch control
exmem_en, exmem_flush  out  1 each  EX/MEM latch control
memwb_en, memwb_flush  out  1 each  MEM/WB latch control
halt  out  1  sticky CPU halted
stall_cnt  out  CNT_W  cycles with PC frozen, not halted
flush_cnt  out  CNT_W  ex_pcsrc squash events
inst_cnt  out  CNT_W  retired instructions

Behaviour:
- State register: RUN, MEMWAIT, HALTED. Latch controls are combinational from state and inputs. State and counters are registered.
- Reset: state=RUN, halt=0, all counters 0. While nRST=0, all en/flush=0 and pc_en=0. Reset mid-operation returns to RUN immediately.
- mem_req = mem_dREN | mem_dWEN. mem_ok = !mem_req | dhit. advance = ihit & mem_ok.
- Load-use: lu = ex_dREN & ex_wsel!=0 & (ex_wsel==id_rsel1 | ex_wsel==id_rsel2).
- RUN / MEMWAIT, case advance=0: pc_en, ifid_en, idex_en and exmem_en are 0. memwb_en=memwb_flush=1 only if !mem_ok, which inserts a WB bubble and prevents a double writeback. Otherwise memwb_en=0.
- Case advance=1 and ex_pcsrc=1 (highest priority):
  - pc_en=1, all en=1.
  - ifid_flush=1, idex_flush=1; the load-use check is ignored.
  - flush_cnt++.
- Case advance=1, !ex_pcsrc, lu=1:
  - pc_en=0, ifid_en=0 (hold).
  - idex_en=1 with idex_flush=1 (bubble).
  - exmem_en=memwb_en=1.
- Case advance=1, no hazard: pc_en=1, all en=1, all flush=0.
- Transitions:
  - RUN->MEMWAIT when mem_req & !dhit.
  - MEMWAIT->RUN when dhit. The exit cycle obeys the advance rules above; if ihit=0 on that cycle the sequencer stays in RUN and stalls on ihit.
  - Any state->HALTED when wb_halt=1; the halting instruction is counted in inst_cnt that cycle.
- HALTED: halt=1, pc_en=0, all en/flush=0, counters frozen. Only nRST exits.
- stall_cnt increments on every non-HALTED cycle with pc_en=0.
- inst_cnt increments when memwb_en & wb_valid & !memwb_flush, or on halt entry.
- All counters saturate at all-ones; no wrap.
- Simultaneous ex_pcsrc and !ihit: no redirect until ihit. ex_pcsrc is held by the frozen ID/EX/EX stages.

Decomposition:
- cpu_types_pkg gains the hazard_state_t enum {RUN, MEMWAIT, HALTED}.
- One sub-module, perf_counter (saturating counter with inc/clear, CNT_W wide), instantiated three times.

Test Plan:
- Reset mid-MEMWAIT: assert nRST=0 -> state RUN, all outputs 0, counters 0.
- Load-use: ex_dREN=1, ex_wsel=8, id_rsel2=8, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle. stall_cnt=1. The same with ex_wsel=0 -> no stall.
- Branch + load-use same cycle: ex_pcsrc=1, lu=1, ihit=1 -> ifid_flush=idex_flush=1, pc_en=1, flush_cnt=1.
- Dcache miss: mem_dREN=1, dhit=0 for 3 cycles then 1 -> MEMWAIT for 3 cycles, memwb_flush=1 in each, exit cycle all en=1. stall_cnt=3.
- Icache miss: ihit=0 for 2 cycles, no mem op -> all en=0, no flush, stall_cnt=2.
- Halt: wb_halt=1 with wb_valid=1 -> halt=1 next cycle and stays 1. inst_cnt frozen; later ihit/dhit activity is ignored.
